// File: rtl/peripheral_dbg_pu_riscv_jsp_jtag_shift.sv
// JTAG-side shifter of the JTAG Serial Port: status capture, then byte slots to/from the JSP core.
// Optional DBG_JSP_WR_CLAMP_EN limits host writes to the free space captured at Capture-DR.
module peripheral_dbg_pu_riscv_jsp_jtag_shift (
    input  logic       tck_i,
    input  logic       rst_i,
    input  logic       module_select_i,
    input  logic       capture_dr_i,
    input  logic       shift_dr_i,
    input  logic       update_dr_i,
    input  logic       tdi_i,
    output logic       tdo_o,
    input  logic [7:0] jsp_data_i,
    input  logic [3:0] jsp_bytes_available_i,
    input  logic [3:0] jsp_bytes_free_i,
    output logic [7:0] jsp_data_o,
    output logic       jsp_rd_strobe_o,
    output logic       jsp_wr_strobe_o,
    output logic       top_inhibit_o
);

    typedef enum logic [1:0] {IDLE, STATUS, DATA} state_t;

    state_t     state;
    logic [7:0] out_sr;
    logic [7:0] in_sr;
    logic [2:0] bit_cnt;
    logic [3:0] rd_left;
    logic [3:0] wr_left;
    logic [3:0] avail_c;
    logic [3:0] free_c;
    logic       rd_loaded;

    logic [7:0] in_next;
    logic [3:0] rd_left_init;
    logic [3:0] wr_left_init;
    logic       scan_exit;

    function automatic logic [3:0] min4(input logic [3:0] a, input logic [3:0] b);
        return (a < b) ? a : b;
    endfunction

    // The byte completed on this edge: tdi_i lands in bit 7 as in_sr shifts right.
    assign in_next      = {tdi_i, in_sr[7:1]};
    assign rd_left_init = min4(in_next[7:4], avail_c);
`ifdef DBG_JSP_WR_CLAMP_EN
    assign wr_left_init = min4(in_next[3:0], free_c);
`else
    assign wr_left_init = in_next[3:0];
`endif

    assign scan_exit = (state != IDLE) && (update_dr_i || capture_dr_i || !module_select_i);
    assign tdo_o     = out_sr[0];

    always_ff @(posedge tck_i or posedge rst_i) begin
        if (rst_i) begin
            state           <= IDLE;
            out_sr          <= 8'h00;
            in_sr           <= 8'h00;
            bit_cnt         <= 3'd0;
            rd_left         <= 4'd0;
            wr_left         <= 4'd0;
            avail_c         <= 4'd0;
            free_c          <= 4'd0;
            rd_loaded       <= 1'b0;
            jsp_data_o      <= 8'h00;
            jsp_rd_strobe_o <= 1'b0;
            jsp_wr_strobe_o <= 1'b0;
            top_inhibit_o   <= 1'b0;
        end else begin
            jsp_rd_strobe_o <= 1'b0;
            jsp_wr_strobe_o <= 1'b0;

            if (capture_dr_i && module_select_i) begin
                state         <= STATUS;
                out_sr        <= {jsp_bytes_free_i, jsp_bytes_available_i};
                avail_c       <= jsp_bytes_available_i;
                free_c        <= jsp_bytes_free_i;
                bit_cnt       <= 3'd0;
                rd_left       <= 4'd0;
                wr_left       <= 4'd0;
                rd_loaded     <= 1'b0;
                top_inhibit_o <= 1'b1;
            end else if (scan_exit) begin
                // Leaving discards counts; a partially shifted slot is never written.
                state         <= IDLE;
                out_sr        <= 8'h00;
                bit_cnt       <= 3'd0;
                rd_left       <= 4'd0;
                wr_left       <= 4'd0;
                rd_loaded     <= 1'b0;
                top_inhibit_o <= 1'b0;
            end else if ((state != IDLE) && shift_dr_i) begin
                in_sr   <= in_next;
                bit_cnt <= bit_cnt + 3'd1;

                if (state == STATUS) begin
                    if (bit_cnt == 3'd7) begin
                        rd_left   <= rd_left_init;
                        wr_left   <= wr_left_init;
                        out_sr    <= (rd_left_init != 4'd0) ? jsp_data_i : 8'h00;
                        rd_loaded <= (rd_left_init != 4'd0);
                        state     <= DATA;
                    end else begin
                        out_sr <= {1'b0, out_sr[7:1]};
                    end
                end else begin
                    // Pop at bit 0 gives the JSP seven edges to present the next head byte.
                    if ((bit_cnt == 3'd0) && rd_loaded) begin
                        jsp_rd_strobe_o <= 1'b1;
                        rd_left         <= rd_left - 4'd1;
                        rd_loaded       <= 1'b0;
                    end

                    if (bit_cnt == 3'd7) begin
                        if (wr_left != 4'd0) begin
                            jsp_data_o      <= in_next;
                            jsp_wr_strobe_o <= 1'b1;
                            wr_left         <= wr_left - 4'd1;
                        end
                        out_sr    <= (rd_left != 4'd0) ? jsp_data_i : 8'h00;
                        rd_loaded <= (rd_left != 4'd0);
                    end else begin
                        out_sr <= {1'b0, out_sr[7:1]};
                    end
                end
            end
        end
    end

endmodule
